pl_kernel_hls_deadlock_trace_ctrl: RTL and testbench

Central controller for the HLS deadlock detection network. Watches the `dl_detect_out` flags of all PROC_NUM per-process detect units and debounces a persistent deadlock. It then elects one origin process and raises the global `dl_detect_in`. It follows the token around the dependency cycle and pushes the visited process IDs into a report FIFO read by the debug/host interface.

---
 rtl/pl_kernel_hls_deadlock_trace_ctrl_pkg.sv | 27 ++
 rtl/pl_kernel_hls_deadlock_trace_ctrl_if.sv | 11 +
 rtl/pl_kernel_hls_deadlock_trace_ctrl_fifo.sv | 57 +++++
 rtl/pl_kernel_hls_deadlock_trace_ctrl.sv | 145 ++++++++++++++
 tb/tb_pl_kernel_hls_deadlock_trace_ctrl.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pl_kernel_hls_deadlock_trace_ctrl_pkg.sv
// Shared types and helpers for the HLS deadlock trace controller.
// Process vectors wider than MAX_PROC are not supported by lowest_set.
package pl_kernel_hls_dl_pkg;

  localparam int MAX_PROC = 64;

  typedef enum logic [1:0] {
    DL_IDLE   = 2'd0,
    DL_ORIGIN = 2'd1,
    DL_TRACE  = 2'd2,
    DL_DONE   = 2'd3
  } dl_state_e;

  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Lowest set index; ties between processes always go to the lower ID.
  function automatic int unsigned lowest_set(input logic [MAX_PROC-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int i = MAX_PROC - 1; i >= 0; i--)
      if (v[i]) idx = unsigned'(i);
    return idx;
  endfunction

endpackage

// File: rtl/pl_kernel_hls_deadlock_trace_ctrl_if.sv
// Report channel carrying visited process IDs to the debug/host side.
interface pl_kernel_hls_dl_report_if #(
  parameter int ID_W = 2
);
  logic            report_valid;
  logic            report_ready;
  logic [ID_W-1:0] report_id;

  modport master (output report_valid, output report_id, input report_ready);
  modport slave  (input report_valid, input report_id, output report_ready);
endinterface

// File: rtl/pl_kernel_hls_deadlock_trace_ctrl_fifo.sv
// First-word-fall-through report FIFO; a push into a full FIFO only
// lands when a pop frees a slot in the same cycle.
module pl_kernel_hls_dl_report_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_pop;
  logic          do_push;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pl_kernel_hls_deadlock_trace_ctrl.sv
// Central deadlock trace controller: debounces detect flags, elects an
// origin, follows the token around the cycle and logs visited IDs.
//
// state  | meaning
// IDLE   | debouncing dl_detect_vec
// ORIGIN | one cycle: pulse origin, raise dl_detect_in, log origin ID
// TRACE  | log each token hit until return to origin or timeout
// DONE   | trace complete, dl_detect_in held until sw_clear
module pl_kernel_hls_deadlock_trace_ctrl
  import pl_kernel_hls_dl_pkg::*;
#(
  parameter int PROC_NUM      = 4,
  parameter int DEBOUNCE      = 16,
  parameter int TRACE_TIMEOUT = 64,
  parameter int FIFO_DEPTH    = 8,
  parameter int ID_W          = id_width(PROC_NUM)
) (
  input  logic                reset,
  input  logic                clock,
  input  logic [PROC_NUM-1:0] dl_detect_vec,
  input  logic [PROC_NUM-1:0] token_hit_vec,
  input  logic                sw_clear,
  output logic                dl_detect_in,
  output logic [PROC_NUM-1:0] origin_vec,
  output logic [PROC_NUM-1:0] token_clear_vec,
  pl_kernel_hls_dl_report_if.master report,
  output logic                busy,
  output logic                done,
  output logic                timeout,
  output logic                overflow,
  output logic                multi_token
);
  localparam logic [1:0] S_IDLE   = DL_IDLE;
  localparam logic [1:0] S_ORIGIN = DL_ORIGIN;
  localparam logic [1:0] S_TRACE  = DL_TRACE;
  localparam logic [1:0] S_DONE   = DL_DONE;
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int HW = $clog2(TRACE_TIMEOUT);

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [DW-1:0]       deb_cnt;
  logic [HW-1:0]       hop_cnt;
  logic [ID_W-1:0]     origin_id;
  logic [PROC_NUM-1:0] origin_1h;
  logic                any_det;
  logic                deb_hit;
  logic                ret_hit;
  logic                hop_last;
  logic                multi_hit;
  logic                push;
  logic [ID_W-1:0]     push_id;
  logic                pop;
  logic                fifo_empty;
  logic                fifo_full;
  logic [ID_W-1:0]     fifo_head;

  assign any_det   = |dl_detect_vec;
  assign deb_hit   = (state == S_IDLE) & any_det & (deb_cnt == DW'(DEBOUNCE - 1));
  assign origin_1h = PROC_NUM'(1) << origin_id;
  assign ret_hit   = (state == S_TRACE) & ~sw_clear
                   & token_hit_vec[origin_id] & dl_detect_vec[origin_id];
  assign hop_last  = (hop_cnt == HW'(TRACE_TIMEOUT - 1));
  assign multi_hit = (token_hit_vec & (token_hit_vec - PROC_NUM'(1))) != '0;

  assign token_clear_vec = ret_hit ? origin_1h : '0;
  assign busy            = (state != S_IDLE);
  assign done            = (state == S_DONE);

  // On the return hit the origin ID is logged even if a lower index also hit.
  always_comb begin
    push    = 1'b0;
    push_id = origin_id;
    if (!sw_clear) begin
      if (state == S_ORIGIN) begin
        push = 1'b1;
      end else if (state == S_TRACE && token_hit_vec != '0) begin
        push = 1'b1;
        if (!ret_hit) push_id = ID_W'(lowest_set(MAX_PROC'(token_hit_vec)));
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (deb_hit) state_nxt = S_ORIGIN;
      S_ORIGIN: state_nxt = S_TRACE;
      S_TRACE:  if (ret_hit || hop_last) state_nxt = S_DONE;
      default:  state_nxt = state;
    endcase
    if (sw_clear && state != S_IDLE) state_nxt = S_IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      deb_cnt      <= '0;
      hop_cnt      <= '0;
      origin_id    <= '0;
      dl_detect_in <= 1'b0;
      origin_vec   <= '0;
      timeout      <= 1'b0;
      overflow     <= 1'b0;
      multi_token  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state != S_IDLE || !any_det || deb_hit) deb_cnt <= '0;
      else                                        deb_cnt <= deb_cnt + DW'(1);
      hop_cnt <= (state == S_TRACE) ? hop_cnt + HW'(1) : '0;
      if (deb_hit) origin_id <= ID_W'(lowest_set(MAX_PROC'(dl_detect_vec)));
      dl_detect_in <= (state_nxt == S_TRACE) || (state_nxt == S_DONE);
      origin_vec   <= (state == S_ORIGIN && !sw_clear) ? origin_1h : '0;
      if (deb_hit) begin
        timeout     <= 1'b0;
        overflow    <= 1'b0;
        multi_token <= 1'b0;
      end else begin
        if (state == S_TRACE && !sw_clear && !ret_hit && hop_last) timeout <= 1'b1;
        if (push && fifo_full && !pop) overflow <= 1'b1;
        if (state == S_TRACE && !sw_clear && multi_hit) multi_token <= 1'b1;
      end
    end
  end

  assign pop                 = ~fifo_empty & report.report_ready;
  assign report.report_valid = ~fifo_empty;
  assign report.report_id    = fifo_head;

  pl_kernel_hls_dl_report_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ID_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (deb_hit),
    .push      (push),
    .push_data (push_id),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_pl_kernel_hls_deadlock_trace_ctrl.sv
// Bench for the deadlock trace controller: directed scenarios followed by
// random stimulus, all checked against a transaction-level reference model.
module tb_pl_kernel_hls_deadlock_trace_ctrl;
  localparam int PN    = 4;
  localparam int DEB   = 4;
  localparam int TT    = 8;
  localparam int DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [PN-1:0] det   = '0;
  logic [PN-1:0] hit   = '0;
  logic          clr   = 1'b0;
  logic          dl_in;
  logic [PN-1:0] org;
  logic [PN-1:0] tclr;
  logic          busy, done, tmo, ovf, multi;

  pl_kernel_hls_dl_report_if #(.ID_W(2)) rep ();

  pl_kernel_hls_deadlock_trace_ctrl #(
    .PROC_NUM      (PN),
    .DEBOUNCE      (DEB),
    .TRACE_TIMEOUT (TT),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .reset           (reset),
    .clock           (clock),
    .dl_detect_vec   (det),
    .token_hit_vec   (hit),
    .sw_clear        (clr),
    .dl_detect_in    (dl_in),
    .origin_vec      (org),
    .token_clear_vec (tclr),
    .report          (rep),
    .busy            (busy),
    .done            (done),
    .timeout         (tmo),
    .overflow        (ovf),
    .multi_token     (multi)
  );

  always #5 clock = ~clock;

  // Reference model: phase, detect run length, trace age and a queue of IDs.
  typedef enum {P_IDLE, P_ORIGIN, P_TRACE, P_DONE} phase_e;
  phase_e   ph;
  int       run, tcyc, oid;
  logic     m_dl, m_tmo, m_ovf, m_multi;
  logic [3:0] m_org;
  int       q[$];

  int       n_assert = 0;
  int       n_fail   = 0;
  int       cyc      = 0;
  int       first_org = -1;
  logic [3:0] tclr_seen = '0;
  int       got[$];

  function automatic int low(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ph = P_IDLE; run = 0; tcyc = 0; oid = 0;
    m_dl = 0; m_org = '0; m_tmo = 0; m_ovf = 0; m_multi = 0;
    q.delete();
  endtask

  task automatic check_all();
    logic [3:0] exp_tc;
    exp_tc = (ph == P_TRACE && !clr && hit[oid] && det[oid]) ? 4'(1 << oid) : 4'b0;
    chk("busy", busy, ph != P_IDLE);
    chk("done", done, ph == P_DONE);
    chk("dl_detect_in", dl_in, m_dl);
    chk("origin_vec", org, m_org);
    chk("token_clear_vec", tclr, exp_tc);
    chk("report_valid", rep.report_valid, q.size() != 0);
    chk("report_id", rep.report_id, (q.size() != 0) ? q[0] : 0);
    chk("timeout", tmo, m_tmo);
    chk("overflow", ovf, m_ovf);
    chk("multi_token", multi, m_multi);
    if (org != 0 && first_org < 0) first_org = cyc;
    tclr_seen = tclr_seen | tclr;
    if (rep.report_valid && rep.report_ready) got.push_back(int'(rep.report_id));
  endtask

  task automatic model_next();
    bit pop, full;
    int hid, nh;
    pop   = (q.size() != 0) && rep.report_ready;
    full  = (q.size() == DEPTH);
    hid   = -1;
    m_org = '0;
    case (ph)
      P_IDLE: begin
        if (det != 0) begin
          run++;
          if (run == DEB) begin
            oid = low(det); q.delete(); pop = 0;
            m_tmo = 0; m_ovf = 0; m_multi = 0;
            ph = P_ORIGIN; run = 0;
          end
        end else run = 0;
      end
      P_ORIGIN: begin
        if (clr) begin ph = P_IDLE; m_dl = 0; end
        else begin m_org = 4'(1 << oid); m_dl = 1; hid = oid; ph = P_TRACE; tcyc = 0; end
      end
      P_TRACE: begin
        if (clr) begin ph = P_IDLE; m_dl = 0; end
        else begin
          tcyc++;
          nh = $countones(hit);
          if (nh > 1) m_multi = 1;
          if (hit[oid] && det[oid]) begin hid = oid; ph = P_DONE; end
          else begin
            if (nh != 0) hid = low(hit);
            if (tcyc == TT) begin m_tmo = 1; ph = P_DONE; end
          end
        end
      end
      default: if (clr) begin ph = P_IDLE; m_dl = 0; end
    endcase
    if (pop) void'(q.pop_front());
    if (hid >= 0) begin
      if (full && !pop) m_ovf = 1;
      else q.push_back(hid);
    end
  endtask

  task automatic step();
    #1;
    check_all();
    model_next();
    @(posedge clock);
    @(negedge clock);
    cyc++;
  endtask

  task automatic go_idle();
    det = '0; hit = '0; clr = 1'b1;
    step();
    clr = 1'b0;
    step();
  endtask

  task automatic scen_start();
    cyc = 0; first_org = -1; tclr_seen = '0; got.delete();
  endtask

  initial begin
    int exp1[4] = '{1, 3, 2, 1};
    int exp4[4] = '{2, 0, 3, 0};
    int exp4b[5] = '{2, 0, 3, 0, 3};
    logic [3:0] hold;

    rep.report_ready = 1'b0;
    model_reset();
    #1;
    chk("reset_dl_in", dl_in, 0);
    chk("reset_busy", busy, 0);
    chk("reset_valid", rep.report_valid, 0);
    chk("reset_origin", org, 0);
    @(negedge clock); @(negedge clock);
    reset = 1'b1;

    // Main trace: origin 1, tokens visit 3, 2 and return to 1.
    scen_start();
    rep.report_ready = 1'b1;
    det = 4'b0110;
    repeat (6) step();
    hit = 4'b1000; step();
    hit = 4'b0100; step();
    hit = 4'b0010; step();
    hit = 4'b0000; repeat (4) step();
    chk("s1_origin_cycle", first_org, 5);
    chk("s1_done", done, 1);
    chk("s1_token_clear", tclr_seen, 4'b0010);
    chk("s1_read_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("s1_read_id", got[i], exp1[i]);
    go_idle();

    // Glitched detect restarts debounce; then a trace with no return times out.
    scen_start();
    det = 4'b1001; repeat (3) step();
    det = 4'b0000; step();
    det = 4'b1001; repeat (DEB + 1 + TT + 3) step();
    chk("s2_origin_cycle", first_org, 9);
    chk("s3_timeout", tmo, 1);
    chk("s3_done", done, 1);
    chk("s3_dl_in", dl_in, 1);
    chk("s3_no_token_clear", tclr_seen, 0);
    go_idle();

    // Consumer stalled: fifth push into a 4-deep FIFO is dropped.
    scen_start();
    rep.report_ready = 1'b0;
    det = 4'b0100; repeat (5) step();
    hit = 4'b0001; step();
    hit = 4'b1000; step();
    hit = 4'b0001; step();
    hit = 4'b1000; step();
    hit = 4'b0000;
    chk("s4_overflow", ovf, 1);
    got.delete();
    rep.report_ready = 1'b1;
    repeat (5) step();
    chk("s4_read_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("s4_read_id", got[i], exp4[i]);
    go_idle();
    chk("s4_overflow_sticky", ovf, 1);

    // Same fill, but a pop in the full cycle lets the push through.
    scen_start();
    rep.report_ready = 1'b0;
    det = 4'b0100; repeat (5) step();
    hit = 4'b0001; step();
    hit = 4'b1000; step();
    hit = 4'b0001; step();
    hit = 4'b1000; rep.report_ready = 1'b1; step();
    hit = 4'b0000; rep.report_ready = 1'b0;
    chk("s4b_no_overflow", ovf, 0);
    rep.report_ready = 1'b1;
    repeat (5) step();
    chk("s4b_read_count", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++) chk("s4b_read_id", got[i], exp4b[i]);
    go_idle();

    // Two simultaneous hits: lowest index logged, multi_token raised.
    scen_start();
    det = 4'b0100; repeat (5) step();
    hit = 4'b1010; step();
    hit = 4'b0000; repeat (3) step();
    chk("s5_multi_token", multi, 1);
    chk("s5_hit_id", (got.size() > 1) ? got[1] : -1, 1);
    go_idle();

    // sw_clear mid-trace keeps undrained entries.
    scen_start();
    rep.report_ready = 1'b0;
    det = 4'b0010; repeat (6) step();
    clr = 1'b1; det = 4'b0000; step();
    clr = 1'b0;
    chk("s6_busy", busy, 0);
    chk("s6_dl_in", dl_in, 0);
    chk("s6_fifo_kept", rep.report_valid, 1);
    rep.report_ready = 1'b1;
    repeat (3) step();

    // Asynchronous reset in the middle of a trace.
    scen_start();
    rep.report_ready = 1'b0;
    det = 4'b0010; repeat (6) step();
    hit = 4'b0010;
    #3 reset = 1'b0;
    #1;
    chk("arst_dl_in", dl_in, 0);
    chk("arst_origin", org, 0);
    chk("arst_token_clear", tclr, 0);
    chk("arst_valid", rep.report_valid, 0);
    chk("arst_id", rep.report_id, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_flags", {tmo, ovf, multi}, 0);
    model_reset();
    @(negedge clock);
    det = '0; hit = '0; reset = 1'b1;
    repeat (2) step();

    // Random traffic.
    hold = '0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) hold = 4'($urandom_range(0, 15));
      det = ($urandom_range(0, 24) == 0) ? 4'b0000 : hold;
      hit = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      rep.report_ready = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 34) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
